// File: rtl/move_scanner.sv
// move_scanner: sequential legal-move finder for an 8x8 disc-flipping board.
// Each empty square is tried against the eight directions in turn. A square is
// legal when a run of one or more opponent discs is capped by one of the mover's
// own discs. The scan handles one state per cycle.
//
// Ports:
//   clk, RST       clock; synchronous active-high reset
//   start          scan request, only looked at in IDLE
//   player         side to move (1 = RED, 0 = BLUE)
//   B, R           blue / red disc bitboards, bit index y*8+x
//   busy, done     busy in every state except IDLE; done is a one-cycle pulse in DONE
//   legal, count   legal-move mask and its population count
//   has_move       count != 0
//   first_x/_y     coordinates of the lowest-index legal square, 0 when there is none
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; results from the last scan are held
// SCAN_SQ | look at square sq; occupied squares are skipped
// CHK_DIR | neighbour of sq in direction dir must hold an opponent disc
// WALK    | follow the opponent run from pos until it hits own/empty/edge
// DONE    | one-cycle completion pulse
module move_scanner #(
  parameter bit STOP_ON_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        start,
  input  logic        player,
  input  logic [63:0] B,
  input  logic [63:0] R,
  output logic        busy,
  output logic        done,
  output logic [63:0] legal,
  output logic [6:0]  count,
  output logic        has_move,
  output logic [2:0]  first_x,
  output logic [2:0]  first_y
);

  typedef enum logic [2:0] {IDLE, SCAN_SQ, CHK_DIR, WALK, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  sq_q, sq_d;
  logic [2:0]  dir_q, dir_d;
  logic [5:0]  pos_q, pos_d;
  logic [63:0] cur_q, cur_d;
  logic [63:0] opp_q, opp_d;
  logic [63:0] legal_q, legal_d;
  logic [6:0]  count_q, count_d;
  logic [2:0]  first_x_q, first_x_d;
  logic [2:0]  first_y_q, first_y_d;

  logic [63:0]       occ;
  logic [5:0]        base_idx;
  logic signed [3:0] dx, dy, nx, ny;
  logic              nb_off;
  logic [5:0]        nb_idx;
  logic              next_dir, adv, mark;

  assign occ = cur_q | opp_q;

  always_comb begin
    dx = 4'sd0;
    dy = 4'sd0;
    case (dir_q)
      3'd0: begin dx =  4'sd1; dy =  4'sd0; end
      3'd1: begin dx = -4'sd1; dy =  4'sd0; end
      3'd2: begin dx =  4'sd0; dy =  4'sd1; end
      3'd3: begin dx =  4'sd0; dy = -4'sd1; end
      3'd4: begin dx =  4'sd1; dy =  4'sd1; end
      3'd5: begin dx = -4'sd1; dy = -4'sd1; end
      3'd6: begin dx = -4'sd1; dy =  4'sd1; end
      default: begin dx = 4'sd1; dy = -4'sd1; end
    endcase
  end

  // One stepper serves both CHK_DIR (from sq) and WALK (from pos). The
  // coordinates range over -1..8, and both extremes have bit 3 set, so bit 3
  // alone flags off-board and a row edge can never wrap into the next row.
  always_comb begin
    base_idx = (state_q == CHK_DIR) ? sq_q : pos_q;
    nx       = $signed({1'b0, base_idx[2:0]}) + dx;
    ny       = $signed({1'b0, base_idx[5:3]}) + dy;
    nb_off   = nx[3] | ny[3];
    nb_idx   = {ny[2:0], nx[2:0]};
  end

  always_comb begin
    state_d   = state_q;
    sq_d      = sq_q;
    dir_d     = dir_q;
    pos_d     = pos_q;
    cur_d     = cur_q;
    opp_d     = opp_q;
    legal_d   = legal_q;
    count_d   = count_q;
    first_x_d = first_x_q;
    first_y_d = first_y_q;
    next_dir  = 1'b0;
    adv       = 1'b0;
    mark      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cur_d     = player ? R : B;
          opp_d     = player ? B : R;
          legal_d   = '0;
          count_d   = '0;
          first_x_d = '0;
          first_y_d = '0;
          sq_d      = '0;
          dir_d     = '0;
          state_d   = SCAN_SQ;
        end
      end
      SCAN_SQ: begin
        if (occ[sq_q]) begin
          adv = 1'b1;
        end else begin
          dir_d   = '0;
          state_d = CHK_DIR;
        end
      end
      CHK_DIR: begin
        if (!nb_off && opp_q[nb_idx]) begin
          pos_d   = nb_idx;
          state_d = WALK;
        end else begin
          next_dir = 1'b1;
        end
      end
      WALK: begin
        if (nb_off || !occ[nb_idx]) begin
          next_dir = 1'b1;
        end else if (opp_q[nb_idx]) begin
          pos_d = nb_idx;
        end else begin
          mark = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (next_dir) begin
      if (dir_q != 3'd7) begin
        dir_d   = dir_q + 3'd1;
        state_d = CHK_DIR;
      end else begin
        adv = 1'b1;
      end
    end

    if (mark) begin
      legal_d[sq_q] = 1'b1;
      count_d       = count_q + 7'd1;
      if (count_q == 7'd0) begin
        first_x_d = sq_q[2:0];
        first_y_d = sq_q[5:3];
      end
      adv = 1'b1;
    end

    if (adv) begin
      if (sq_q == 6'd63 || (mark && STOP_ON_FIRST)) begin
        state_d = DONE;
      end else begin
        sq_d    = sq_q + 6'd1;
        state_d = SCAN_SQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q   <= IDLE;
      sq_q      <= '0;
      dir_q     <= '0;
      pos_q     <= '0;
      cur_q     <= '0;
      opp_q     <= '0;
      legal_q   <= '0;
      count_q   <= '0;
      first_x_q <= '0;
      first_y_q <= '0;
    end else begin
      state_q   <= state_d;
      sq_q      <= sq_d;
      dir_q     <= dir_d;
      pos_q     <= pos_d;
      cur_q     <= cur_d;
      opp_q     <= opp_d;
      legal_q   <= legal_d;
      count_q   <= count_d;
      first_x_q <= first_x_d;
      first_y_q <= first_y_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign legal    = legal_q;
  assign count    = count_q;
  assign has_move = (count_q != 7'd0);
  assign first_x  = first_x_q;
  assign first_y  = first_y_q;

endmodule

// File: tb/tb_move_scanner.sv
module tb_move_scanner;

  logic        clk = 1'b0;
  logic        RST, start0, start1, player;
  logic [63:0] B, R;

  logic        busy0, done0, has0, busy1, done1, has1;
  logic [63:0] legal0, legal1;
  logic [6:0]  count0, count1;
  logic [2:0]  fx0, fy0, fx1, fy1;

  always #5 clk = ~clk;

  move_scanner #(.STOP_ON_FIRST(1'b0)) dut0 (
    .clk(clk), .RST(RST), .start(start0), .player(player), .B(B), .R(R),
    .busy(busy0), .done(done0), .legal(legal0), .count(count0),
    .has_move(has0), .first_x(fx0), .first_y(fy0));

  move_scanner #(.STOP_ON_FIRST(1'b1)) dut1 (
    .clk(clk), .RST(RST), .start(start1), .player(player), .B(B), .R(R),
    .busy(busy1), .done(done1), .legal(legal1), .count(count1),
    .has_move(has1), .first_x(fx1), .first_y(fy1));

  bit sel;
  logic        busy_s, done_s, has_s;
  logic [63:0] legal_s;
  logic [6:0]  count_s;
  logic [2:0]  fx_s, fy_s;
  assign busy_s  = sel ? busy1  : busy0;
  assign done_s  = sel ? done1  : done0;
  assign has_s   = sel ? has1   : has0;
  assign legal_s = sel ? legal1 : legal0;
  assign count_s = sel ? count1 : count0;
  assign fx_s    = sel ? fx1    : fx0;
  assign fy_s    = sel ? fy1    : fy0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain board walk over x/y integers, with a cycle tally of
  // 1 per square, 1 per direction tried and 1 per opponent disc walked past.
  task automatic model(input logic [63:0] b, input logic [63:0] r, input bit p, input bit stop,
                       output logic [63:0] lg, output int cnt, output int fx, output int fy,
                       output int lat);
    logic [63:0] cur, opp, occ;
    int dxs[8];
    int dys[8];
    int x, y, k;
    bit found, stopped;
    dxs = '{1, -1, 0, 0, 1, -1, -1, 1};
    dys = '{0, 0, 1, -1, 1, -1, 1, -1};
    cur = p ? r : b;
    opp = p ? b : r;
    occ = cur | opp;
    lg = '0; cnt = 0; fx = 0; fy = 0; lat = 0; stopped = 0;
    for (int s = 0; s < 64 && !stopped; s++) begin
      lat++;
      if (occ[s]) continue;
      found = 0;
      for (int d = 0; d < 8 && !found; d++) begin
        lat++;
        x = s % 8 + dxs[d];
        y = s / 8 + dys[d];
        k = 0;
        while (x >= 0 && x <= 7 && y >= 0 && y <= 7 && opp[y*8+x]) begin
          k++;
          x += dxs[d];
          y += dys[d];
        end
        if (k > 0) begin
          lat += k;
          if (x >= 0 && x <= 7 && y >= 0 && y <= 7 && cur[y*8+x]) found = 1;
        end
      end
      if (found) begin
        lg[s] = 1'b1;
        if (cnt == 0) begin fx = s % 8; fy = s / 8; end
        cnt++;
        if (stop) stopped = 1;
      end
    end
  endtask

  task automatic run_scan(input string tag, input bit which, input logic [63:0] b,
                          input logic [63:0] r, input bit p,
                          output logic [63:0] o_lg, output int o_cnt, output int o_fx,
                          output int o_fy, output int o_lat);
    logic [63:0] e_lg;
    int e_cnt, e_fx, e_fy, e_lat, cyc;
    bit got;
    model(b, r, p, which, e_lg, e_cnt, e_fx, e_fy, e_lat);
    @(negedge clk);
    sel = which;
    B = b; R = r; player = p;
    start0 = !which; start1 = which;
    @(posedge clk);
    @(negedge clk);
    start0 = 0; start1 = 0;
    // inputs change after the start edge; the running scan must not see them
    B = {$urandom, $urandom}; R = {$urandom, $urandom}; player = ~p;
    cyc = 0; got = 0;
    while (!got && cyc < 4000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 5 && e_lat > 10) begin start0 = !which; start1 = which; end
      else begin start0 = 0; start1 = 0; end
      if (done_s) got = 1;
    end
    start0 = 0; start1 = 0;
    chk({tag, " done_seen"}, got, 1'b1);
    chk({tag, " latency"}, cyc, e_lat);
    chk({tag, " busy_in_done"}, busy_s, 1'b1);
    chk({tag, " legal"}, legal_s, e_lg);
    chk({tag, " count"}, count_s, e_cnt);
    chk({tag, " has_move"}, has_s, e_cnt != 0);
    chk({tag, " first_x"}, fx_s, e_fx);
    chk({tag, " first_y"}, fy_s, e_fy);
    o_lg = legal_s; o_cnt = count_s; o_fx = fx_s; o_fy = fy_s; o_lat = cyc;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " done_pulse_end"}, done_s, 1'b0);
    chk({tag, " busy_after"}, busy_s, 1'b0);
    chk({tag, " legal_hold"}, legal_s, e_lg);
    chk({tag, " count_hold"}, count_s, e_cnt);
  endtask

  typedef struct {
    string       name;
    logic [63:0] b;
    logic [63:0] r;
    bit          p;
    bit          stop;
    logic [63:0] lg;
    int          cnt;
    int          fx;
    int          fy;
    int          lat;
  } vec_t;

  vec_t vecs[6];
  localparam logic [63:0] OPEN_R = (64'd1 << 27) | (64'd1 << 36);
  localparam logic [63:0] OPEN_B = (64'd1 << 28) | (64'd1 << 35);

  initial begin
    logic [63:0] o_lg, rb, rr;
    int o_cnt, o_fx, o_fy, o_lat, ndone;

    vecs[0] = '{"open_blue", OPEN_B, OPEN_R, 1'b0, 1'b0,
                (64'd1 << 19) | (64'd1 << 26) | (64'd1 << 37) | (64'd1 << 44), 4, 3, 2, -1};
    vecs[1] = '{"open_red", OPEN_B, OPEN_R, 1'b1, 1'b0,
                (64'd1 << 20) | (64'd1 << 29) | (64'd1 << 34) | (64'd1 << 43), 4, 4, 2, -1};
    vecs[2] = '{"edge_wrap", 64'd1 << 8, 64'd1 << 7, 1'b0, 1'b0, 64'd0, 0, 0, 0, -1};
    vecs[3] = '{"empty", 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 0, 0, 0, 576};
    vecs[4] = '{"full", {64{1'b1}}, 64'd0, 1'b0, 1'b0, 64'd0, 0, 0, 0, 64};
    vecs[5] = '{"stop_first", OPEN_B, OPEN_R, 1'b0, 1'b1, 64'd1 << 19, 1, 3, 2, -1};

    sel = 0; RST = 1; start0 = 0; start1 = 0; player = 0; B = '0; R = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy", {busy0, busy1}, 2'b00);
    chk("rst done", {done0, done1}, 2'b00);
    chk("rst legal", legal0 | legal1, 64'd0);
    chk("rst count", {count0, count1}, 14'd0);
    chk("rst has_move", {has0, has1}, 2'b00);
    chk("rst first", {fx0, fy0, fx1, fy1}, 12'd0);
    RST = 0;

    for (int i = 0; i < 6; i++) begin
      run_scan(vecs[i].name, vecs[i].stop, vecs[i].b, vecs[i].r, vecs[i].p,
               o_lg, o_cnt, o_fx, o_fy, o_lat);
      chk({vecs[i].name, " tbl_legal"}, o_lg, vecs[i].lg);
      chk({vecs[i].name, " tbl_count"}, o_cnt, vecs[i].cnt);
      chk({vecs[i].name, " tbl_first"}, {o_fx[2:0], o_fy[2:0]},
          {vecs[i].fx[2:0], vecs[i].fy[2:0]});
      if (vecs[i].lat >= 0) chk({vecs[i].name, " tbl_latency"}, o_lat, vecs[i].lat);
    end

    // reset 10 cycles into a scan that has already marked square 0
    @(negedge clk);
    sel = 0; B = 64'd1 << 2; R = 64'd1 << 1; player = 0; start0 = 1;
    @(posedge clk);
    @(negedge clk);
    start0 = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("midscan count_before_rst", count0, 7'd1);
    RST = 1;
    @(posedge clk);
    @(negedge clk);
    chk("midscan rst busy", busy0, 1'b0);
    chk("midscan rst done", done0, 1'b0);
    chk("midscan rst legal", legal0, 64'd0);
    chk("midscan rst count", count0, 7'd0);
    chk("midscan rst has_move", has0, 1'b0);
    RST = 0;
    ndone = 0;
    repeat (30) begin
      @(posedge clk);
      @(negedge clk);
      if (done0 || busy0) ndone++;
    end
    chk("midscan no_done_after_rst", ndone, 0);
    run_scan("after_rst", 1'b0, 64'd1 << 2, 64'd1 << 1, 1'b0, o_lg, o_cnt, o_fx, o_fy, o_lat);

    // reset wins over start in the same cycle
    @(negedge clk);
    RST = 1; start0 = 1; B = OPEN_B; R = OPEN_R;
    @(posedge clk);
    @(negedge clk);
    RST = 0; start0 = 0;
    chk("rst_vs_start busy", busy0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_vs_start busy_later", busy0, 1'b0);
    chk("rst_vs_start count", count0, 7'd0);

    for (int i = 0; i < 40; i++) begin
      rb = {$urandom, $urandom} & {$urandom, $urandom};
      rr = {$urandom, $urandom} & {$urandom, $urandom} & ~rb;
      if (i % 3 == 0) rb = rb | {$urandom, $urandom};
      rr = rr & ~rb;
      run_scan($sformatf("rand%0d", i), (i % 4) == 3, rb, rr, $urandom_range(0, 1),
               o_lg, o_cnt, o_fx, o_fy, o_lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/move_scanner.md
MOVE_SCANNER -- requirements
Module: move_scanner

Interface
REQ-001 SHALL have parameter STOP_ON_FIRST, default 0: when 1, the scan ends at the first legal square found.
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request a scan; sampled only in IDLE.
REQ-005 SHALL have port player  input  1  side to move: 1 = RED, 0 = BLUE.
REQ-006 SHALL have port B  input  64  blue discs; bit index y*8+x.
REQ-007 SHALL have port R  input  64  red discs; bit index y*8+x.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse, high while in DONE.
REQ-010 SHALL have port legal  output  64  legal-move mask; bit y*8+x set when that square is a legal move.
REQ-011 SHALL have port count  output  7  number of set bits in legal.
REQ-012 SHALL have port has_move  output  1  count != 0.
REQ-013 SHALL have ports first_x and first_y  output  3 each  coordinates of the lowest-index legal square; 0 when none.

Function
REQ-014 SHALL, on start in IDLE, latch cur = (player ? R : B) and opp = (player ? B : R), clear legal/count/first_*/has_move, set sq = 0, and enter SCAN_SQ.
REQ-015 SHALL ignore changes on B, R and player after the start edge until the next accepted start.
REQ-016 SHALL ignore start while busy.
REQ-017 SHALL treat a square as occupied when (cur|opp) is set at its index, including the invalid overlap case.
REQ-018 SHALL implement states IDLE, SCAN_SQ, CHK_DIR, WALK and DONE, with exactly one state visit per clock cycle.
REQ-019 SHALL, in SCAN_SQ, go to CHK_DIR with dir = 0 when sq is empty, and advance the square when sq is occupied.
REQ-020 SHALL use direction encoding dir 0..7 = E(+1,0), W(-1,0), S(0,+1), N(0,-1), SE(+1,+1), NW(-1,-1), SW(-1,+1), NE(+1,-1), with y increasing downward.
REQ-021 SHALL, in CHK_DIR, compute the neighbour of sq in direction dir; when the neighbour is on the board and opp is set there, pos = neighbour and enter WALK, otherwise take the next direction.
REQ-022 SHALL, in WALK, step pos by dir; when the step leaves the board or lands on an empty square, take the next direction; on opp, stay in WALK; on cur, mark sq legal and advance the square without checking the remaining directions.
REQ-023 SHALL do all bounds checks on 4-bit signed x/y with off-board when x or y < 0 or > 7; index arithmetic SHALL never wrap across row edges.
REQ-024 SHALL, on next direction, go to CHK_DIR with dir+1 when dir < 7, and advance the square when dir = 7.
REQ-025 SHALL, on advance square, enter DONE when sq = 63, otherwise set sq+1 and enter SCAN_SQ.
REQ-026 SHALL, on marking legal, set legal[sq], increment count, and load first_x/first_y from sq when count was 0.
REQ-027 SHALL, when STOP_ON_FIRST = 1, enter DONE directly after the first legal mark.
REQ-028 SHALL have DONE last one cycle with done = 1, then return to IDLE.
REQ-029 SHALL hold legal, count, has_move and first_* stable from DONE until the next accepted start.
REQ-030 SHALL give latency from the start edge to done of 1 + sum over squares of (1 + CHK_DIR cycles + WALK cycles); an all-empty board gives done in the cycle after edge 576, and a full board in the cycle after edge 64.

Reset
REQ-031 SHALL, on RST, enter IDLE and clear busy, done, legal, count, has_move, first_x and first_y to 0.
REQ-032 SHALL, when RST is asserted mid-scan, abort the scan with no done pulse.
REQ-033 SHALL give RST priority over start in the same cycle.

Verification
REQ-034 SHALL cover the opening position: R = bits 27 and 36, B = bits 28 and 35, player = 0 -> legal = bits 19, 26, 37 and 44, count = 4, first = (3,2), has_move = 1.
REQ-035 SHALL cover the same board with player = 1 -> legal = bits 20, 29, 34 and 43, count = 4, first = (4,2).
REQ-036 SHALL cover the edge wrap: R = bit 7, B = bit 8, player = 0 -> legal = 0, count = 0, has_move = 0, first = (0,0).
REQ-037 SHALL cover timing: all-empty board -> done high exactly in the cycle after edge 576; all-ones B -> done in the cycle after edge 64, legal = 0.
REQ-038 SHALL cover STOP_ON_FIRST = 1 with the opening position, player = 0 -> count = 1, legal = bit 19 only, done pulses once.
REQ-039 SHALL cover RST asserted 10 cycles after start -> busy = 0 next cycle, outputs 0, no done; a later start then completes normally.
